// File: rtl/vector_load_store_unit.sv
// rtl/vector_load_store_unit.sv - moves 512-bit vectors between word memory and the vector register file
// Store path is built only when VLSU_STORE_EN is defined; otherwise store commands finish with err.
module vector_load_store_unit #(
    parameter int ADDR_W = 16,
    parameter int BEAT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_store,
    input  logic [1:0]        cmd_reg,
    input  logic [ADDR_W-1:0] cmd_addr,
    output logic              done,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BEAT_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [BEAT_W-1:0] mem_rdata,
    output logic              rf_write_en,
    output logic [1:0]        rf_write_sel,
    output logic [511:0]      rf_write_data,
    output logic [1:0]        rf_read_sel,
    input  logic [511:0]      rf_read_data
);
    localparam int NBEATS = 512 / BEAT_W;
    localparam int CNT_W  = $clog2(NBEATS + 1);
    localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CNT_W-1:0] NB  = CNT_W'(NBEATS);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_STORE, ST_FIN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]   recv_cnt_q, recv_cnt_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [1:0]         reg_q, reg_d;
    logic               store_q, store_d;
    logic [511:0]       buf_q, buf_d;

    logic               load_req;
    logic               store_req;
    logic               fin_load;
    logic [IDX_W-1:0]   recv_idx;

    assign load_req = (state_q == ST_LOAD) && (issue_cnt_q < NB);
    assign recv_idx = recv_cnt_q[IDX_W-1:0];
    assign fin_load = (state_q == ST_FIN) && !store_q;

`ifdef VLSU_STORE_EN
    logic [IDX_W-1:0]   issue_idx;
    assign issue_idx = issue_cnt_q[IDX_W-1:0];
    assign store_req = (state_q == ST_STORE);
`else
    logic unused_rd;
    assign unused_rd = ^rf_read_data;
    assign store_req = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        base_d      = base_q;
        reg_d       = reg_q;
        store_d     = store_q;
        buf_d       = buf_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    base_d      = cmd_addr;
                    reg_d       = cmd_reg;
                    store_d     = cmd_store;
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
                    if (cmd_store) begin
`ifdef VLSU_STORE_EN
                        buf_d   = rf_read_data;
                        state_d = ST_STORE;
`else
                        state_d = ST_FIN;
`endif
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (load_req && mem_gnt) begin
                    issue_cnt_d = issue_cnt_q + ONE;
                end
                // Responses arrive in order, so recv_cnt alone picks the destination beat.
                if (mem_rvalid && (recv_cnt_q < NB)) begin
                    buf_d[int'(recv_idx)*BEAT_W +: BEAT_W] = mem_rdata;
                    recv_cnt_d = recv_cnt_q + ONE;
                    if (recv_cnt_q == NB - ONE) begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_STORE: begin
`ifdef VLSU_STORE_EN
                if (mem_gnt) begin
                    issue_cnt_d = issue_cnt_q + ONE;
                    if (issue_cnt_q == NB - ONE) begin
                        state_d = ST_FIN;
                    end
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            base_q      <= '0;
            reg_q       <= '0;
            store_q     <= 1'b0;
            buf_q       <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            base_q      <= base_d;
            reg_q       <= reg_d;
            store_q     <= store_d;
            buf_q       <= buf_d;
        end
    end

    // Outputs are forced low while reset is held, even before the reset edge lands.
    assign cmd_ready   = reset && (state_q == ST_IDLE);
    assign rf_read_sel = (reset && (state_q == ST_IDLE)) ? cmd_reg : 2'd0;
    assign mem_req     = reset && (load_req || store_req);
    assign mem_we      = reset && store_req;
    assign mem_addr    = (reset && (load_req || store_req)) ?
                         ADDR_W'(base_q + ADDR_W'(issue_cnt_q)) : '0;
`ifdef VLSU_STORE_EN
    assign mem_wdata   = (reset && store_req) ? buf_q[int'(issue_idx)*BEAT_W +: BEAT_W] : '0;
    assign done        = reset && (state_q == ST_FIN);
    assign err         = 1'b0;
`else
    assign mem_wdata   = '0;
    assign done        = reset && fin_load;
    assign err         = reset && (state_q == ST_FIN) && store_q;
`endif
    assign rf_write_en   = reset && fin_load;
    assign rf_write_sel  = (reset && fin_load) ? reg_q : 2'd0;
    assign rf_write_data = (reset && fin_load) ? buf_q : '0;

endmodule

// File: tb/tb_vector_load_store_unit.sv
// tb/tb_vector_load_store_unit.sv - directed self-checking bench for vector_load_store_unit
module tb_vector_load_store_unit;
    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_valid, cmd_ready, cmd_store;
    logic [1:0]   cmd_reg;
    logic [15:0]  cmd_addr;
    logic         done, err;
    logic         mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [15:0]  mem_addr;
    logic [31:0]  mem_wdata, mem_rdata;
    logic         rf_write_en;
    logic [1:0]   rf_write_sel, rf_read_sel;
    logic [511:0] rf_write_data, rf_read_data;

    vector_load_store_unit dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_store(cmd_store),
        .cmd_reg(cmd_reg), .cmd_addr(cmd_addr), .done(done), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rf_write_en(rf_write_en), .rf_write_sel(rf_write_sel), .rf_write_data(rf_write_data),
        .rf_read_sel(rf_read_sel), .rf_read_data(rf_read_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Memory image: word at address a is 0xA0 + (a - 0x100) mod 2^16.
    function automatic logic [31:0] word_of(input logic [15:0] a);
        logic [15:0] off;
        off = a - 16'h0100;
        return 32'h0000_00A0 + {16'h0000, off};
    endfunction

    typedef struct { logic [15:0] addr; int ready; } pend_t;
    pend_t pend[$];
    bit gnt_random = 1'b0;
    int max_delay = 1;
    bit stray_rv = 1'b0;

    initial begin
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!reset) pend.delete();
            else if (mem_req && mem_gnt && !mem_we)
                pend.push_back('{mem_addr, cyc + ((max_delay <= 1) ? 1 : int'($urandom_range(1, max_delay)))});
            @(posedge clk); #1;
            mem_gnt = gnt_random ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stray_rv) begin
                mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
            end else if (pend.size() > 0 && pend[0].ready <= cyc) begin
                mem_rvalid = 1'b1; mem_rdata = word_of(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                mem_rvalid = 1'b0; mem_rdata = '0;
            end
        end
    end

    int we_total = 0, we_cyc = 0, done_total = 0, err_total = 0, rv_total = 0;
    int stable_viol = 0, nz_reset = 0;
    logic [1:0] we_sel;
    logic [511:0] we_data;
    logic [15:0] rd_addr_q[$], wr_addr_q[$];
    int rd_cyc_q[$];
    logic [31:0] wr_data_q[$];
    bit hold_pending = 1'b0;
    logic [15:0] h_addr;
    logic [31:0] h_wdata;
    logic h_we;

    initial forever begin
        @(negedge clk);
        if (rf_write_en) begin we_total++; we_cyc = cyc; we_sel = rf_write_sel; we_data = rf_write_data; end
        if (done) done_total++;
        if (err) err_total++;
        if (mem_rvalid && reset) rv_total++;
        if (mem_req && mem_gnt && !mem_we) begin rd_addr_q.push_back(mem_addr); rd_cyc_q.push_back(cyc); end
        if (mem_req && mem_gnt && mem_we) begin wr_addr_q.push_back(mem_addr); wr_data_q.push_back(mem_wdata); end
        if (mem_req && hold_pending && (mem_addr !== h_addr || mem_we !== h_we || mem_wdata !== h_wdata))
            stable_viol++;
        hold_pending = mem_req && !mem_gnt;
        h_addr = mem_addr; h_we = mem_we; h_wdata = mem_wdata;
        if (!reset && (cmd_ready || done || err || mem_req || mem_we || mem_addr != 0 || mem_wdata != 0 ||
                       rf_write_en || rf_write_sel != 0 || rf_write_data != 0 || rf_read_sel != 0))
            nz_reset++;
    end

    task automatic drive_cmd(input bit st, input logic [1:0] r, input logic [15:0] a, output int c0);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_store = st; cmd_reg = r; cmd_addr = a;
        c0 = cyc;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_fin(input int budget, output int f, output bit ok);
        ok = 1'b0; f = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done || err) begin f = cyc; ok = 1'b1; return; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; cmd_valid = 1'b1; cmd_store = 1'b0; cmd_reg = 2'd3; cmd_addr = 16'h1234;
        rf_read_data = '0;
        repeat (3) @(negedge clk);
        checks++; if (cmd_ready !== 1'b0 || mem_req !== 1'b0 || rf_read_sel !== 2'd0)
            begin errors++; $display("FAIL reset_outputs ready=%b req=%b rsel=%0d want 0 0 0", cmd_ready, mem_req, rf_read_sel); end
        cmd_valid = 1'b0;
        @(posedge clk); #1; reset = 1'b1;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1)
            begin errors++; $display("FAIL reset_release_ready got %b want 1", cmd_ready); end
        checks++; if (rf_read_sel !== 2'd3)
            begin errors++; $display("FAIL idle_read_sel got %0d want 3", rf_read_sel); end
        checks++; if (nz_reset !== 0)
            begin errors++; $display("FAIL reset_nonzero_outputs got %0d want 0", nz_reset); end
    endtask

    task automatic test_load();
        int c0, f, n0, we0, d0; bit ok;
        n0 = rd_addr_q.size(); we0 = we_total; d0 = done_total;
        drive_cmd(1'b0, 2'd2, 16'h0100, c0);
        wait_fin(60, f, ok);
        checks++; if (!ok) begin errors++; $display("FAIL load_timeout got none want done"); return; end
        @(negedge clk);
        checks++; if (f !== c0 + 18) begin errors++; $display("FAIL load_done_cycle got %0d want %0d", f - c0, 18); end
        checks++; if (we_cyc !== c0 + 18) begin errors++; $display("FAIL load_we_cycle got %0d want %0d", we_cyc - c0, 18); end
        checks++; if (we_total - we0 !== 1 || done_total - d0 !== 1)
            begin errors++; $display("FAIL load_pulses we=%0d done=%0d want 1 1", we_total - we0, done_total - d0); end
        checks++; if (we_sel !== 2'd2) begin errors++; $display("FAIL load_sel got %0d want 2", we_sel); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (we_data[i*32 +: 32] !== 32'(32'hA0 + i))
                begin errors++; $display("FAIL load_beat%0d got %h want %h", i, we_data[i*32 +: 32], 32'(32'hA0 + i)); end
        end
        checks++; if (rd_addr_q.size() - n0 !== 16 || rd_cyc_q[n0] !== c0 + 1 || rd_cyc_q[n0+15] !== c0 + 16)
            begin errors++; $display("FAIL load_req_window n=%0d first=%0d want 16 1", rd_addr_q.size() - n0, rd_cyc_q[n0] - c0); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL load_ready_after got %b want 1", cmd_ready); end
    endtask

    task automatic test_store();
        int c0, f, w0, we0, d0, e0, r0; bit ok;
        for (int i = 0; i < 16; i++) rf_read_data[i*32 +: 32] = 32'(32'h5000 + i);
        w0 = wr_addr_q.size(); we0 = we_total; d0 = done_total; e0 = err_total; r0 = rd_addr_q.size();
        drive_cmd(1'b1, 2'd1, 16'h0020, c0);
        wait_fin(60, f, ok);
        checks++; if (!ok) begin errors++; $display("FAIL store_timeout got none want fin"); return; end
        @(negedge clk);
        checks++; if (we_total - we0 !== 0) begin errors++; $display("FAIL store_rf_write got %0d want 0", we_total - we0); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL store_ready_after got %b want 1", cmd_ready); end
`ifdef VLSU_STORE_EN
        checks++; if (f !== c0 + 17) begin errors++; $display("FAIL store_done_cycle got %0d want 17", f - c0); end
        checks++; if (done_total - d0 !== 1 || err_total - e0 !== 0)
            begin errors++; $display("FAIL store_pulses done=%0d err=%0d want 1 0", done_total - d0, err_total - e0); end
        checks++; if (wr_addr_q.size() - w0 !== 16) begin errors++; $display("FAIL store_writes got %0d want 16", wr_addr_q.size() - w0); return; end
        for (int i = 0; i < 16; i++) begin
            checks++; if (wr_addr_q[w0+i] !== 16'(16'h20 + i) || wr_data_q[w0+i] !== 32'(32'h5000 + i))
                begin errors++; $display("FAIL store_beat%0d got %h/%h want %h/%h", i, wr_addr_q[w0+i], wr_data_q[w0+i], 16'(16'h20 + i), 32'(32'h5000 + i)); end
        end
`else
        checks++; if (f !== c0 + 1) begin errors++; $display("FAIL store_err_cycle got %0d want 1", f - c0); end
        checks++; if (err_total - e0 !== 1 || done_total - d0 !== 0)
            begin errors++; $display("FAIL store_pulses err=%0d done=%0d want 1 0", err_total - e0, done_total - d0); end
        checks++; if (wr_addr_q.size() - w0 !== 0 || rd_addr_q.size() - r0 !== 0)
            begin errors++; $display("FAIL store_mem_traffic got %0d want 0", wr_addr_q.size() - w0 + rd_addr_q.size() - r0); end
`endif
    endtask

    task automatic test_backpressure();
        int c0, f, we0, d0, s0; bit ok;
        gnt_random = 1'b1; max_delay = 5;
        we0 = we_total; d0 = done_total; s0 = stable_viol;
        drive_cmd(1'b0, 2'd0, 16'h0100, c0);
        wait_fin(400, f, ok);
        gnt_random = 1'b0; max_delay = 1;
        checks++; if (!ok) begin errors++; $display("FAIL bp_timeout got none want done"); return; end
        repeat (10) @(negedge clk);
        checks++; if (stable_viol - s0 !== 0) begin errors++; $display("FAIL bp_stable got %0d want 0", stable_viol - s0); end
        checks++; if (done_total - d0 !== 1 || we_total - we0 !== 1)
            begin errors++; $display("FAIL bp_once done=%0d we=%0d want 1 1", done_total - d0, we_total - we0); end
        checks++; if (we_sel !== 2'd0) begin errors++; $display("FAIL bp_sel got %0d want 0", we_sel); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (we_data[i*32 +: 32] !== 32'(32'hA0 + i))
                begin errors++; $display("FAIL bp_beat%0d got %h want %h", i, we_data[i*32 +: 32], 32'(32'hA0 + i)); end
        end
    endtask

    task automatic test_wrap();
        int c0, f, n0; bit ok;
        n0 = rd_addr_q.size();
        drive_cmd(1'b0, 2'd3, 16'hFFF8, c0);
        wait_fin(60, f, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout got none want done"); return; end
        @(negedge clk);
        checks++; if (rd_addr_q[n0] !== 16'hFFF8 || rd_addr_q[n0+7] !== 16'hFFFF ||
                      rd_addr_q[n0+8] !== 16'h0000 || rd_addr_q[n0+15] !== 16'h0007)
            begin errors++; $display("FAIL wrap_addr got %h %h %h %h want fff8 ffff 0000 0007", rd_addr_q[n0], rd_addr_q[n0+7], rd_addr_q[n0+8], rd_addr_q[n0+15]); end
        checks++; if (we_data[0 +: 32] !== 32'h0000_FF98) begin errors++; $display("FAIL wrap_beat0 got %h want 0000ff98", we_data[0 +: 32]); end
        checks++; if (we_data[7*32 +: 32] !== 32'h0000_FF9F) begin errors++; $display("FAIL wrap_beat7 got %h want 0000ff9f", we_data[7*32 +: 32]); end
        checks++; if (we_data[8*32 +: 32] !== 32'h0000_FFA0) begin errors++; $display("FAIL wrap_beat8 got %h want 0000ffa0", we_data[8*32 +: 32]); end
        checks++; if (we_data[15*32 +: 32] !== 32'h0000_FFA7) begin errors++; $display("FAIL wrap_beat15 got %h want 0000ffa7", we_data[15*32 +: 32]); end
        checks++; if (we_sel !== 2'd3) begin errors++; $display("FAIL wrap_sel got %0d want 3", we_sel); end
    endtask

    task automatic test_reset_mid_load();
        int c0, f, rv0, we0, d0, z0; bit ok, hit;
        rv0 = rv_total; we0 = we_total; d0 = done_total; z0 = nz_reset;
        drive_cmd(1'b0, 2'd1, 16'h0100, c0);
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (rv_total - rv0 >= 7) hit = 1'b1;
        end
        checks++; if (!hit) begin errors++; $display("FAIL midrst_wait got %0d want 7 responses", rv_total - rv0); end
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        checks++; if (mem_req !== 1'b0 || cmd_ready !== 1'b0 || done !== 1'b0)
            begin errors++; $display("FAIL midrst_outputs req=%b ready=%b done=%b want 0 0 0", mem_req, cmd_ready, done); end
        repeat (2) @(posedge clk);
        #1; reset = 1'b1;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", cmd_ready); end
        stray_rv = 1'b1;
        repeat (3) @(posedge clk);
        #1; stray_rv = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (we_total - we0 !== 0 || done_total - d0 !== 0)
            begin errors++; $display("FAIL midrst_no_write we=%0d done=%0d want 0 0", we_total - we0, done_total - d0); end
        checks++; if (nz_reset - z0 !== 0) begin errors++; $display("FAIL midrst_nonzero got %0d want 0", nz_reset - z0); end
        drive_cmd(1'b0, 2'd1, 16'h0100, c0);
        wait_fin(60, f, ok);
        checks++; if (!ok) begin errors++; $display("FAIL midrst_reload_timeout got none want done"); return; end
        @(negedge clk);
        checks++; if (f !== c0 + 18 || we_total - we0 !== 1 || we_sel !== 2'd1)
            begin errors++; $display("FAIL midrst_reload lat=%0d we=%0d sel=%0d want 18 1 1", f - c0, we_total - we0, we_sel); end
        checks++; if (we_data[0 +: 32] !== 32'h0000_00A0 || we_data[15*32 +: 32] !== 32'h0000_00AF)
            begin errors++; $display("FAIL midrst_reload_data got %h %h want 000000a0 000000af", we_data[0 +: 32], we_data[15*32 +: 32]); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_backpressure();
        test_wrap();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vector_load_store_unit.md
# vector_load_store_unit

Moves whole 512-bit vectors between a BEAT_W-wide word memory and the 4-entry vector register file. A load streams 512/BEAT_W consecutive words from memory, assembles them and commits them through the register file's write port; a store captures a register through the read port and streams it out as consecutive words. It sits directly upstream of the register file: its write outputs feed `write_sel`/`write_data`/`write_en`, and its read select drives `read_sel`.

## Interface
- ADDR_W, 16, memory word-address width
- BEAT_W, 32, memory data width; must divide 512; NBEATS = 512/BEAT_W (16 at default)
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset (reset==0 at a rising edge clears the block)
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command (IDLE only)
- cmd_store  in  1  1 = store (register to memory), 0 = load
- cmd_reg  in  2  vector register index
- cmd_addr  in  ADDR_W  base word address
- done  out  1  one-cycle pulse, command completed
- err  out  1  one-cycle pulse, command rejected
- mem_req  out  1  memory request
- mem_we  out  1  1 = write request
- mem_addr  out  ADDR_W  request word address
- mem_wdata  out  BEAT_W  write data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read response valid; responses in order, at least 1 cycle after their grant
- mem_rdata  in  BEAT_W  read response data
- rf_write_en  out  1  register file write enable
- rf_write_sel  out  2  register file write index
- rf_write_data  out  512  register file write data
- rf_read_sel  out  2  register file read index
- rf_read_data  in  512  register file combinational read data

## Operation
- States: IDLE, LOAD, STORE, FIN.
- IDLE: cmd_ready=1; rf_read_sel = cmd_reg. On cmd_valid: latch cmd_reg, cmd_addr and cmd_store; clear issue_cnt and recv_cnt. A load goes to LOAD. A store captures rf_read_data into the buffer and goes to STORE.
- LOAD: mem_req=1, mem_we=0, mem_addr = base+issue_cnt while issue_cnt<NBEATS. Each mem_gnt increments issue_cnt.
- LOAD, response handling: each mem_rvalid writes mem_rdata into buffer bits [recv_cnt*BEAT_W +: BEAT_W] and increments recv_cnt. The lowest address lands in the LSBs.
- LOAD exit: when recv_cnt reaches NBEATS, go to FIN.
- STORE: mem_req=1, mem_we=1, mem_addr = base+issue_cnt, mem_wdata = buffer beat issue_cnt. Each grant increments issue_cnt. The grant of beat NBEATS-1 moves the block to FIN.
- FIN (one cycle): done=1; for a load, also rf_write_en=1, rf_write_sel = latched reg, rf_write_data = buffer. Then return to IDLE.
- Address arithmetic: base+i is taken modulo 2^ADDR_W, so 0xFFFF+1 wraps to 0x0000.
- mem_rvalid is ignored in IDLE, STORE and FIN, and in LOAD once recv_cnt==NBEATS.
- When mem_req=1 and mem_gnt=0, mem_addr, mem_we and mem_wdata hold stable.
- Reset (any state, mid-transfer included): return to IDLE; clear counters and buffer. All outputs go to 0 while reset==0; cmd_ready rises in the first cycle after release. A half-finished load never writes the register file.

## Timing
- rf_write_sel and rf_write_data are registered; rf_write_en is asserted for exactly one cycle per load.
- Load with mem_gnt tied to 1 and rvalid arriving 1 cycle after grant: accept at cycle 0, requests in cycles 1..16, responses in cycles 2..17, FIN (done, rf_write_en) in cycle 18.
- Store with mem_gnt tied to 1: accept at cycle 0, writes in cycles 1..16, done in cycle 17.
- Each cycle of mem_gnt=0 adds one cycle to the latency. cmd_ready returns in the cycle after FIN.
- Store-then-load to the same register: the store captures the value present at acceptance.

## Configuration
- VLSU_STORE_EN defined: store commands behave as above.
- VLSU_STORE_EN undefined: the STORE path and its buffer-capture mux are removed. A store command is still accepted, then goes straight to FIN with err=1 and done=0. There is no memory traffic and no register write.

## Test plan
- Load: memory words 0x100..0x10F = 0xA0+i, cmd load reg 2 addr 0x100, gnt=1 -> cycle 18: rf_write_en=1, sel=2, data beat i = 0xA0+i, done=1.
- Store: rf_read_data = beat i = 0x5000+i, cmd store reg 1 addr 0x20 -> 16 writes to 0x20..0x2F with data 0x5000..0x500F; done in cycle 17; rf_write_en stays 0.
- Backpressure: random mem_gnt and random response delays 1..5 -> addresses and data stay stable while un-granted; load data is correct; done occurs exactly once.
- Wrap: load from 0xFFF8 -> requests go to 0xFFF8..0xFFFF then 0x0000..0x0007; beat 8 = mem[0x0000].
- Reset mid-load: reset=0 after 7 responses -> no rf_write_en; all outputs 0; a subsequent load completes correctly. Stray rvalid in IDLE is ignored.
- Macro off: store command -> err pulse one cycle after acceptance, no mem_req, cmd_ready back the following cycle.
